// File: rtl/x86_ins_encoder.sv
// Serialising x86-64 instruction encoder: takes one structured instruction per
// handshake, builds its byte image, and streams it out one byte per cycle.
module x86_ins_encoder #(
  parameter int MAX_LEN = 15,
  parameter bit B2B     = 1'b1
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [8:0]  lock_rep,
  input  logic [8:0]  seg_pfx,
  input  logic        opsize_pfx,
  input  logic        addrsz_pfx,
  input  logic [8:0]  rex,
  input  logic [1:0]  opc_len,
  input  logic [23:0] opc,
  input  logic [8:0]  modrm,
  input  logic [8:0]  sib,
  input  logic [2:0]  disp_len,
  input  logic [31:0] disp,
  input  logic [3:0]  imm_len,
  input  logic [63:0] imm,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [7:0]  out_byte,
  output logic        out_first,
  output logic        out_last,
  output logic [3:0]  out_len,
  output logic        err_len,
  output logic        err_fmt
);

  typedef enum logic {IDLE = 1'b0, EMIT = 1'b1} state_t;

  state_t      state, state_n;
  logic [7:0]  cand_p0 [32];
  logic [4:0]  len_p0;
  logic        fmt_bad_p0, len_bad_p0;
  logic [7:0]  img_p1 [15];
  logic [3:0]  len_p1, idx_p1, idx_n;
  logic        err_len_p1, err_fmt_p1, err_len_n, err_fmt_n;
  logic        load, acc, take;

  // Stage p0: pack present fields in wire order; the running position doubles as the length
  always_comb begin
    cand_p0 = '{default: 8'h00};
    len_p0  = '0;
    if (lock_rep[8]) begin cand_p0[len_p0] = lock_rep[7:0]; len_p0 = len_p0 + 5'd1; end
    if (seg_pfx[8])  begin cand_p0[len_p0] = seg_pfx[7:0];  len_p0 = len_p0 + 5'd1; end
    if (opsize_pfx)  begin cand_p0[len_p0] = 8'h66;         len_p0 = len_p0 + 5'd1; end
    if (addrsz_pfx)  begin cand_p0[len_p0] = 8'h67;         len_p0 = len_p0 + 5'd1; end
    if (rex[8])      begin cand_p0[len_p0] = rex[7:0];      len_p0 = len_p0 + 5'd1; end
    for (int i = 0; i < 3; i++)
      if (i < int'(opc_len)) begin
        cand_p0[len_p0] = opc[23-8*i -: 8];
        len_p0 = len_p0 + 5'd1;
      end
    if (modrm[8])    begin cand_p0[len_p0] = modrm[7:0];    len_p0 = len_p0 + 5'd1; end
    if (sib[8])      begin cand_p0[len_p0] = sib[7:0];      len_p0 = len_p0 + 5'd1; end
    for (int i = 0; i < 4; i++)
      if (i < int'(disp_len)) begin
        cand_p0[len_p0] = disp[8*i +: 8];
        len_p0 = len_p0 + 5'd1;
      end
    for (int i = 0; i < 8; i++)
      if (i < int'(imm_len)) begin
        cand_p0[len_p0] = imm[8*i +: 8];
        len_p0 = len_p0 + 5'd1;
      end
  end

  assign fmt_bad_p0 = (opc_len == 2'd0)
                    || !(disp_len inside {3'd0, 3'd1, 3'd2, 3'd4})
                    || !(imm_len inside {4'd0, 4'd1, 4'd2, 4'd4, 4'd8})
                    || (sib[8] && !modrm[8])
                    || ((disp_len != 3'd0) && !modrm[8])
                    || (rex[8] && (rex[7:4] != 4'h4));
  assign len_bad_p0 = (len_p0 > 5'(MAX_LEN));

  assign out_valid = (state == EMIT);
  assign out_first = out_valid && (idx_p1 == 4'd0);
  assign out_last  = out_valid && (idx_p1 == len_p1 - 4'd1);
  assign out_byte  = out_valid ? img_p1[idx_p1] : 8'h00;
  assign out_len   = out_valid ? len_p1 : 4'd0;
  assign take      = out_valid && out_ready;
  assign in_ready  = reset_n && ((state == IDLE) || (B2B && out_last && take));
  assign acc       = in_valid && in_ready;
  assign err_len   = err_len_p1;
  assign err_fmt   = err_fmt_p1;

  always_comb begin
    state_n   = state;
    idx_n     = idx_p1;
    load      = 1'b0;
    err_fmt_n = 1'b0;
    err_len_n = 1'b0;
    case (state)
      IDLE: ;
      EMIT:
        if (take) begin
          if (out_last) state_n = IDLE;
          else          idx_n   = idx_p1 + 4'd1;
        end
      default: state_n = IDLE;
    endcase
    // acc can only be high in IDLE or as the last byte leaves, so it overrides the exit
    if (acc) begin
      if (fmt_bad_p0)      err_fmt_n = 1'b1;
      else if (len_bad_p0) err_len_n = 1'b1;
      else begin
        state_n = EMIT;
        idx_n   = 4'd0;
        load    = 1'b1;
      end
    end
  end

  // Stage p1: control state, byte index and error pulses
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state      <= IDLE;
      idx_p1     <= 4'd0;
      err_len_p1 <= 1'b0;
      err_fmt_p1 <= 1'b0;
    end else begin
      state      <= state_n;
      idx_p1     <= idx_n;
      err_len_p1 <= err_len_n;
      err_fmt_p1 <= err_fmt_n;
    end
  end

  // Stage p1: latched image and length, only read while emitting
  always_ff @(posedge clk) begin
    if (load) begin
      for (int i = 0; i < 15; i++) img_p1[i] <= cand_p0[i];
      len_p1 <= len_p0[3:0];
    end
  end

endmodule
